imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 120 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a 2-entry output FIFO and a saturating illegal-opcode counter.
// Decode happens on acceptance; the FIFO head is presented with a valid/ready handshake.
module imm_gen_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          inst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 flush_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [XLEN-1:0]      imm_o,
  output logic [2:0]           fmt_o,
  output logic                 illegal_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam logic [2:0] FmtR   = 3'd0;
  localparam logic [2:0] FmtI   = 3'd1;
  localparam logic [2:0] FmtS   = 3'd2;
  localparam logic [2:0] FmtB   = 3'd3;
  localparam logic [2:0] FmtU   = 3'd4;
  localparam logic [2:0] FmtJ   = 3'd5;
  localparam logic [2:0] FmtIll = 3'd7;

  localparam logic [ERR_CNT_W-1:0] ErrMax = {ERR_CNT_W{1'b1}};

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  entry_t                 mem_q [2];
  entry_t                 dec;
  entry_t                 head;
  logic                   rd_ptr_q;
  logic                   wr_ptr;
  logic [1:0]             count_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q;
  logic [31:0]            imm32;
  logic                   sgn;
  logic                   push;
  logic                   pop;

  assign sgn = inst_i[31];

  always_comb begin
    imm32       = '0;
    dec.fmt     = FmtIll;
    dec.illegal = 1'b0;
    unique case (inst_i[6:0])
      7'b0110011: dec.fmt = FmtR;
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec.fmt = FmtI;
        imm32   = {{20{sgn}}, inst_i[31:20]};
      end
      7'b0100011: begin
        dec.fmt = FmtS;
        imm32   = {{20{sgn}}, inst_i[31:25], inst_i[11:7]};
      end
      7'b1100011: begin
        dec.fmt = FmtB;
        imm32   = {{19{sgn}}, sgn, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FmtU;
        imm32   = {inst_i[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt = FmtJ;
        imm32   = {{11{sgn}}, sgn, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      end
      default: dec.illegal = 1'b1;
    endcase
    // Every format's 32-bit immediate already carries inst[31] in its MSB.
    dec.imm = XLEN'(signed'(imm32));
  end

  assign ready_o = (count_q < 2'd2) && !rst_i;
  assign valid_o = (count_q != 2'd0);
  assign push    = valid_i && ready_o && !flush_i;
  assign pop     = valid_o && ready_i;
  assign wr_ptr  = rd_ptr_q ^ count_q[0];
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr] <= dec;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q   <= 2'd0;
      rd_ptr_q  <= 1'b0;
      err_cnt_q <= '0;
    end else if (flush_i) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q <= count_q + 2'(push) - 2'(pop);
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (push && dec.illegal && (err_cnt_q != ErrMax)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign imm_o     = valid_o ? head.imm : '0;
  assign fmt_o     = valid_o ? head.fmt : 3'd0;
  assign illegal_o = valid_o ? head.illegal : 1'b0;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table vectors plus handshake, flush and reset sequences.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_i, valid_i, flush_i, ready_i;
  logic [31:0] inst_i;
  logic        ready_o, valid_o, illegal_o;
  logic [31:0] imm_o;
  logic [2:0]  fmt_o;
  logic [7:0]  err_cnt_o;
  logic        ready64, valid64, illegal64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [7:0]  err64;

  int total = 0;
  int bad   = 0;
  int exp_err;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .ERR_CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .inst_i(inst_i), .valid_i(valid_i), .ready_o(ready_o),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i), .imm_o(imm_o), .fmt_o(fmt_o),
    .illegal_o(illegal_o), .err_cnt_o(err_cnt_o)
  );

  imm_gen_pipe #(.XLEN(64), .ERR_CNT_W(8)) dut64 (
    .clk_i(clk), .rst_i(rst_i), .inst_i(inst_i), .valid_i(valid_i), .ready_o(ready64),
    .flush_i(flush_i), .valid_o(valid64), .ready_i(ready_i), .imm_o(imm64), .fmt_o(fmt64),
    .illegal_o(illegal64), .err_cnt_o(err64)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
    step();
    rst_i = 1'b0;
    #1;
    exp_err = 0;
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 1'b0};
    vecs[2]  = '{32'h0000006F, 64'h0,                 3'd5, 1'b0};
    vecs[3]  = '{32'h00000033, 64'h0,                 3'd0, 1'b0};
    vecs[4]  = '{32'h00A12223, 64'h4,                 3'd2, 1'b0};
    vecs[5]  = '{32'h12345037, 64'h12345000,          3'd4, 1'b0};
    vecs[6]  = '{32'h800000B7, 64'hFFFFFFFF_80000000, 3'd4, 1'b0};
    vecs[7]  = '{32'h7FF00067, 64'h7FF,               3'd1, 1'b0};
    vecs[8]  = '{32'hFFC4A303, 64'hFFFFFFFF_FFFFFFFC, 3'd1, 1'b0};
    vecs[9]  = '{32'hFFDFF06F, 64'hFFFFFFFF_FFFFFFFC, 3'd5, 1'b0};
    vecs[10] = '{32'h00208463, 64'h8,                 3'd3, 1'b0};
    vecs[11] = '{32'h0000007F, 64'h0,                 3'd7, 1'b1};
    vecs[12] = '{32'hFFFFFF80, 64'h0,                 3'd7, 1'b1};

    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0; inst_i = '0;
    step(); step();
    chk("rst_valid", valid_o, 0);
    chk("rst_imm", imm_o, 0);
    chk("rst_fmt", fmt_o, 0);
    chk("rst_ill", illegal_o, 0);
    chk("rst_err", err_cnt_o, 0);
    chk("rst_ready", ready_o, 0);
    rst_i = 1'b0;
    #1;
    chk("post_rst_ready", ready_o, 1);
    exp_err = 0;

    // Decode table: push one, observe it the next cycle, let it drain.
    ready_i = 1'b1;
    foreach (vecs[i]) begin
      inst_i = vecs[i].inst; valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      if (vecs[i].ill && exp_err < 255) exp_err++;
      chk($sformatf("v%0d_valid", i), valid_o, 1);
      chk($sformatf("v%0d_imm", i), imm_o, vecs[i].imm64[31:0]);
      chk($sformatf("v%0d_fmt", i), fmt_o, vecs[i].fmt);
      chk($sformatf("v%0d_ill", i), illegal_o, vecs[i].ill);
      chk($sformatf("v%0d_imm64", i), imm64, vecs[i].imm64);
      chk($sformatf("v%0d_err", i), err_cnt_o, exp_err);
      step();
      chk($sformatf("v%0d_drain", i), valid_o, 0);
    end

    // Back-to-back pushes with ready_i=1: one per cycle, in order.
    inst_i = vecs[0].inst; valid_i = 1'b1;
    step();
    chk("tp0_imm", imm_o, vecs[0].imm64[31:0]);
    inst_i = vecs[1].inst;
    step();
    chk("tp1_imm", imm_o, vecs[1].imm64[31:0]);
    chk("tp1_ready", ready_o, 1);
    inst_i = vecs[4].inst;
    step();
    valid_i = 1'b0;
    chk("tp2_fmt", fmt_o, 2);
    step();
    chk("tp_empty", valid_o, 0);

    // Backpressure: third push refused, two drain in order.
    ready_i = 1'b0; valid_i = 1'b1; inst_i = vecs[5].inst;
    step();
    chk("bp_ready1", ready_o, 1);
    inst_i = vecs[9].inst;
    step();
    chk("bp_ready_full", ready_o, 0);
    inst_i = vecs[10].inst;
    step();
    step();
    valid_i = 1'b0;
    chk("bp_hold_valid", valid_o, 1);
    chk("bp_hold_imm", imm_o, 32'h12345000);
    ready_i = 1'b1;
    step();
    chk("bp_second_imm", imm_o, 32'hFFFFFFFC);
    chk("bp_second_fmt", fmt_o, 5);
    chk("bp_ready_back", ready_o, 1);
    step();
    chk("bp_drained", valid_o, 0);

    // Illegal-opcode flood: counter saturates at 255.
    do_reset();
    inst_i = 32'h0000007F; valid_i = 1'b1; ready_i = 1'b1;
    for (int k = 0; k < 300; k++) begin
      step();
      if (exp_err < 255) exp_err++;
      if (fmt_o !== 3'd7 || illegal_o !== 1'b1 || imm_o !== 32'h0 || valid_o !== 1'b1)
        chk($sformatf("flood%0d_out", k), {valid_o, illegal_o, fmt_o, imm_o}, {2'b11, 3'd7, 32'h0});
      chk($sformatf("flood%0d_err", k), err_cnt_o, exp_err);
    end
    valid_i = 1'b0;
    step();
    chk("flood_sat", err_cnt_o, 255);

    // Flush from FULL with a presented instruction.
    do_reset();
    ready_i = 1'b0; valid_i = 1'b1; inst_i = 32'h0000007F;
    step();
    inst_i = 32'h00000093;
    step();
    chk("fl_full", ready_o, 0);
    chk("fl_err_pre", err_cnt_o, 1);
    flush_i = 1'b1; inst_i = 32'h0000007F;
    step();
    flush_i = 1'b0; valid_i = 1'b0;
    chk("fl_valid", valid_o, 0);
    chk("fl_ready", ready_o, 1);
    chk("fl_err", err_cnt_o, 1);
    chk("fl_imm", imm_o, 0);

    // Reset from FULL.
    valid_i = 1'b1; inst_i = 32'hFFF00093;
    step(); step();
    chk("rs_full", ready_o, 0);
    valid_i = 1'b0; rst_i = 1'b1;
    step();
    chk("rs_valid", valid_o, 0);
    chk("rs_imm", imm_o, 0);
    chk("rs_fmt", fmt_o, 0);
    chk("rs_ill", illegal_o, 0);
    chk("rs_err", err_cnt_o, 0);
    chk("rs_ready", ready_o, 0);
    rst_i = 1'b0;
    #1;
    chk("rs_ready_after", ready_o, 1);
    valid_i = 1'b1; ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("rs_first_valid", valid_o, 1);
    chk("rs_first_imm", imm_o, 32'hFFFFFFFF);
    step();
    chk("rs_first_drain", valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
